// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 pooling block.
package pool_pkg;

  localparam int unsigned INTEGER_BITS     = 9;
  localparam int unsigned FIXED_POINT_BITS = 4;
  localparam int unsigned W                = INTEGER_BITS + FIXED_POINT_BITS;

  typedef logic signed [W-1:0] pool_word_t;

  typedef struct packed {
    logic last_col;
    logic last_frame;
  } pool_tag_t;

  // One FIFO entry: pooled pixel in the upper bits, position tags below.
  typedef struct packed {
    pool_word_t data;
    pool_tag_t  tag;
  } pool_beat_t;

  localparam logic signed [W+1:0] SAT_HI = (W+2)'(2**(W-1) - 1);
  localparam logic signed [W+1:0] SAT_LO = (W+2)'(-(2**(W-1)));

  // Signed maximum; on a tie either operand is the same value.
  function automatic pool_word_t pool_max(input pool_word_t a, input pool_word_t b);
    return (a > b) ? a : b;
  endfunction

  // Clamp a W+2 bit signed value into the W bit signed range.
  function automatic pool_word_t pool_sat(input logic signed [W+1:0] x);
    if (x > SAT_HI) return SAT_HI[W-1:0];
    if (x < SAT_LO) return SAT_LO[W-1:0];
    return x[W-1:0];
  endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous show-ahead FIFO for pooled pixels; a full FIFO still accepts
// a write when a read frees a slot in the same cycle.
module pool_out_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 window pooling into a tagged ready/valid pixel stream.
// Build option POOL_AVG_EN: rounded average pooling instead of max pooling.
module max_pool_2x2
  import pool_pkg::*;
#(
  parameter int unsigned OUT_COLS   = 256,
  parameter int unsigned OUT_ROWS   = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [4*W-1:0] i_window,
  input  logic           i_window_valid,
  output logic [W-1:0]   o_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic           o_last_col,
  output logic           o_last_frame,
  output logic           o_overflow
);

  localparam int unsigned CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int unsigned RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int unsigned BW = W + 2;

  pool_word_t r00, r01, r10, r11;
  assign r00 = i_window[4*W-1 -: W];
  assign r01 = i_window[3*W-1 -: W];
  assign r10 = i_window[2*W-1 -: W];
  assign r11 = i_window[W-1 -: W];

  logic       v1, v2;
  pool_word_t p;

`ifdef POOL_AVG_EN
  localparam logic signed [W+1:0] RND = (W+2)'(2);

  logic signed [W:0]   m0, m1;
  logic signed [W+1:0] s2;
  logic signed [W+1:0] rnd;

  // Pairwise row sums, then total sum.
  always_ff @(posedge i_clk) begin
    m0 <= {r00[W-1], r00} + {r01[W-1], r01};
    m1 <= {r10[W-1], r10} + {r11[W-1], r11};
    s2 <= {m0[W], m0} + {m1[W], m1};
  end

  assign rnd = (s2 + RND) >>> 2;
  assign p   = pool_sat(rnd);
`else
  pool_word_t m0, m1, s2;

  // Pairwise row maxima, then overall maximum.
  always_ff @(posedge i_clk) begin
    m0 <= pool_max(r00, r01);
    m1 <= pool_max(r10, r11);
    s2 <= pool_max(m0, m1);
  end

  assign p = s2;
`endif

  // Pipeline valids; reset discards anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= i_window_valid;
      v2 <= v1;
    end
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          at_last_col;
  logic          at_last_row;

  assign at_last_col = (col == CW'(OUT_COLS - 1));
  assign at_last_row = (row == RW'(OUT_ROWS - 1));

  // Frame position advances on every write attempt, dropped or not.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (v2) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  pool_beat_t wr_beat;
  pool_beat_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign wr_beat.data           = p;
  assign wr_beat.tag.last_col   = at_last_col;
  assign wr_beat.tag.last_frame = at_last_col && at_last_row;
  assign pop                    = o_valid && i_ready;

  pool_out_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (v2),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_valid      = !fifo_empty;
  assign o_data       = fifo_empty ? '0 : head.data;
  assign o_last_col   = !fifo_empty && head.tag.last_col;
  assign o_last_frame = !fifo_empty && head.tag.last_frame;

  // Sticky flag for a result lost to a full FIFO with no pop.
  always_ff @(posedge i_clk) begin
    if (i_rst)                             o_overflow <= 1'b0;
    else if (v2 && fifo_full && !pop)      o_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 (small frame: 4 columns x 2 rows).
module tb_max_pool_2x2;
  import pool_pkg::*;

  localparam int unsigned OC = 4;
  localparam int unsigned OR = 2;
  localparam int unsigned FD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*W-1:0] window;
  logic           window_valid;
  logic [W-1:0]   data;
  logic           valid;
  logic           ready;
  logic           last_col;
  logic           last_frame;
  logic           overflow;

  always #5 clk = ~clk;

  max_pool_2x2 #(
    .OUT_COLS   (OC),
    .OUT_ROWS   (OR),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_window       (window),
    .i_window_valid (window_valid),
    .o_data         (data),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_last_col     (last_col),
    .o_last_frame   (last_frame),
    .o_overflow     (overflow)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         lc;
    logic         lf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcol   = 0;
  int   mrow   = 0;

  function automatic logic [W-1:0] wv(input int v);
    return W'(v);
  endfunction

`ifdef POOL_AVG_EN
  function automatic logic [W-1:0] ref_avg(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'($signed(c)) + int'($signed(d));
    s = (s + 2) >>> 2;
    if (s > 4095) s = 4095;
    if (s < -4096) s = -4096;
    return W'(s);
  endfunction
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one window (called just after a rising edge); queue its result if it will be kept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] d, input logic [W-1:0] e, input bit keep);
    exp_t x;
    window       = {a, b, c, d};
    window_valid = 1'b1;
    x.data = e;
    x.lc   = (mcol == OC - 1);
    x.lf   = (mcol == OC - 1) && (mrow == OR - 1);
    if (keep) q.push_back(x);
    if (mcol == OC - 1) begin
      mcol = 0;
      mrow = (mrow == OR - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
    @(posedge clk); #1;
    window_valid = 1'b0;
  endtask

  task automatic send_eq(input int v, input bit keep);
    send(wv(v), wv(v), wv(v), wv(v), wv(v), keep);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    window_valid = 1'b0;
    q.delete();
    mcol = 0;
    mrow = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=0 pending", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each accepted pixel and checks stability while stalled.
  logic [W-1:0] hold_data;
  logic         hold_lc, hold_lf, hold_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && valid) begin
        check("stall_data", int'(data), int'(hold_data));
        check("stall_tags", int'({last_col, last_frame}), int'({hold_lc, hold_lf}));
      end
      if (valid && ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", data);
        end else begin
          e = q.pop_front();
          check("out_data", int'(data), int'(e.data));
          check("out_last_col", int'(last_col), int'(e.lc));
          check("out_last_frame", int'(last_frame), int'(e.lf));
        end
        hold_v = 1'b0;
      end else if (valid) begin
        hold_v    = 1'b1;
        hold_data = data;
        hold_lc   = last_col;
        hold_lf   = last_frame;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    rst          = 1'b1;
    window       = '0;
    window_valid = 1'b0;
    ready        = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_last_col", int'(last_col), 0);
    check("rst_last_frame", int'(last_frame), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    idle(1);

    // Latency and arithmetic on directed windows.
`ifdef POOL_AVG_EN
    send(wv(4), wv(4), wv(4), wv(5), wv(4), 1'b1);
`else
    send(wv(5), wv(-3), wv(7), wv(2), wv(7), 1'b1);
`endif
    check("lat_n1", int'(valid), 0);
    idle(1);
    check("lat_n2", int'(valid), 0);
    idle(1);
    check("lat_n3", int'(valid), 1);
`ifdef POOL_AVG_EN
    send(wv(-1), wv(-1), wv(-1), wv(-2), wv(-1), 1'b1);
    send(wv(12'hFFF), wv(12'hFFF), wv(12'hFFF), wv(12'hFFF), wv(12'hFFF), 1'b1);
`else
    send(wv(-8), wv(-1), wv(-4), wv(-2), wv(-1), 1'b1);
    send(wv(13'h1FFF), wv(13'h1FFF), wv(13'h1FFF), wv(13'h1FFF), wv(13'h1FFF), 1'b1);
    send(wv(-100), wv(-200), wv(-50), wv(-300), wv(-50), 1'b1);
    send(wv(4095), wv(-4096), wv(0), wv(1), wv(4095), 1'b1);
`endif
    wait_drain("directed");

    // Tagging across a full frame and the wrap into the next.
    do_reset();
    for (int i = 1; i <= 9; i++) send_eq(i, 1'b1);
    wait_drain("tags");

    // Overflow: stalled output, six windows, last two dropped.
    do_reset();
    ready = 1'b0;
    for (int i = 11; i <= 16; i++) send_eq(i, i <= 14);
    idle(6);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(valid), 1);
    check("ovf_head", int'(data), 11);
    ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_empty", int'(valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Reset with FIFO half full and two windows in flight.
    ready = 1'b0;
    send_eq(21, 1'b1);
    send_eq(22, 1'b1);
    idle(3);
    send_eq(23, 1'b1);
    send_eq(24, 1'b1);
    do_reset();
    check("rst2_valid", int'(valid), 0);
    check("rst2_overflow", int'(overflow), 0);
    ready = 1'b1;
    idle(5);
    for (int i = 25; i <= 28; i++) send_eq(i, 1'b1);
    wait_drain("rst2");

    // Full FIFO with a push and a pop on the same edge.
    do_reset();
    ready = 1'b0;
    for (int i = 31; i <= 34; i++) send_eq(i, 1'b1);
    idle(4);
    check("full_valid", int'(valid), 1);
    send_eq(35, 1'b1);
    idle(1);
    ready = 1'b1;
    wait_drain("full_push_pop");
    idle(1);
    check("full_no_overflow", int'(overflow), 0);

`ifdef POOL_AVG_EN
    // Random windows against the reference average.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b, c, d;
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      d = W'($urandom);
      send(a, b, c, d, ref_avg(a, b, c, d), 1'b1);
    end
    wait_drain("random");
`endif

    idle(4);
    check("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
